// File: rtl/decoder_proj_encoder.sv
// Hamming(7,4) pad encoder: buffers one 4-bit symbol, drives its codeword on io_out
// for HOLD_CYCLES cycles, then IDLE_CODE for GAP_CYCLES cycles.
module decoder_proj_encoder #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 1,
   parameter logic [6:0]  IDLE_CODE   = 7'b0000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [6:0] io_out,
   output logic [6:0] io_oeb,
   output logic       out_valid,
   output logic       busy,
   output logic [7:0] sym_count,
   output logic [1:0] dbg_state
);

   // Handshake: a symbol transfers on a rising clk edge where in_valid && in_ready;
   // in_ready never depends on in_valid and is low while rst_n is low.

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_GAP = 2'd2} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES);
   localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] buf_q, buf_d;
   logic       buf_full_q, buf_full_d;
   logic [6:0] io_out_q, io_out_d;
   logic       out_valid_q, out_valid_d;
   logic       busy_q, busy_d;
   logic [7:0] sym_count_q, sym_count_d;
   logic       load_now;
   logic       accept;

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic p0, p1, p2;
      p0 = d[0] ^ d[1] ^ d[3];
      p1 = d[0] ^ d[2] ^ d[3];
      p2 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p2, d[0], p1, p0};
   endfunction

   always_comb begin
      load_now    = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      io_out_d    = io_out_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         ST_IDLE: begin
            if (buf_full_q) load_now = 1'b1;
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               if (GAP_CYCLES != 0) begin
                  state_d     = ST_GAP;
                  cnt_d       = 8'd1;
                  io_out_d    = IDLE_CODE;
                  out_valid_d = 1'b0;
               end else if (buf_full_q) begin
                  load_now = 1'b1;
               end else begin
                  state_d     = ST_IDLE;
                  io_out_d    = IDLE_CODE;
                  out_valid_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               if (buf_full_q) load_now = 1'b1;
               else            state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A launch overrides whatever the current state decided.
      if (load_now) begin
         state_d     = ST_HOLD;
         cnt_d       = 8'd1;
         io_out_d    = encode(buf_q);
         out_valid_d = 1'b1;
      end
   end

   assign in_ready = rst_n && (!buf_full_q || load_now);
   assign accept   = in_valid && in_ready;

   always_comb begin
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      if (accept) begin
         buf_d      = in_data;
         buf_full_d = 1'b1;
      end else if (load_now) begin
         buf_full_d = 1'b0;
      end
      sym_count_d = sym_count_q + {7'd0, load_now};
      busy_d      = buf_full_d || (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 8'd0;
         buf_q       <= 4'd0;
         buf_full_q  <= 1'b0;
         io_out_q    <= IDLE_CODE;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sym_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         io_out_q    <= io_out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         sym_count_q <= sym_count_d;
      end
   end

   assign io_out    = io_out_q;
   assign io_oeb    = 7'b0000000;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sym_count = sym_count_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_decoder_proj_encoder.sv
// Bench for decoder_proj_encoder: instance A (HOLD=4, GAP=1) under a pad-timing
// monitor and scoreboard, instance B (HOLD=1, GAP=0) for streaming and wrap.
module tb_decoder_proj_encoder;

   localparam int         HOLD_A = 4;
   localparam int         GAP_A  = 1;
   localparam logic [6:0] IDLE   = 7'b0000000;

   logic       clk, rst_n;
   logic [3:0] a_in_data, b_in_data;
   logic       a_in_valid, b_in_valid, a_in_ready, b_in_ready;
   logic [6:0] a_io_out, b_io_out, a_io_oeb, b_io_oeb;
   logic       a_out_valid, b_out_valid, a_busy, b_busy;
   logic [7:0] a_sym_count, b_sym_count;
   logic [1:0] a_dbg_state, b_dbg_state;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic [3:0] data;
      logic [6:0] code;
   } vec_t;
   vec_t vecs[7];

   decoder_proj_encoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .IDLE_CODE(7'b0000000)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .io_out(a_io_out), .io_oeb(a_io_oeb),
      .out_valid(a_out_valid), .busy(a_busy), .sym_count(a_sym_count),
      .dbg_state(a_dbg_state)
   );

   decoder_proj_encoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .IDLE_CODE(7'b0000000)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .io_out(b_io_out), .io_oeb(b_io_oeb),
      .out_valid(b_out_valid), .busy(b_busy), .sym_count(b_sym_count),
      .dbg_state(b_dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Classic positional Hamming code: bit k of the codeword sits at position k+1,
   // parity bits at positions 1,2,4 cover every position containing that weight.
   function automatic logic [6:0] model_encode(input logic [3:0] d);
      logic [7:0] pos;
      int dpos[4];
      dpos = '{3, 5, 6, 7};
      pos  = '0;
      for (int i = 0; i < 4; i++) pos[dpos[i]] = d[i];
      for (int p = 1; p <= 4; p = p * 2) begin
         logic par;
         par = 1'b0;
         for (int k = 1; k <= 7; k++)
            if (((k & p) != 0) && (k != p)) par = par ^ pos[k];
         pos[p] = par;
      end
      return pos[7:1];
   endfunction

   function automatic logic [2:0] model_syndrome(input logic [6:0] c);
      logic [2:0] s;
      s = 3'd0;
      for (int k = 1; k <= 7; k++) if (c[k-1]) s = s ^ 3'(k);
      return s;
   endfunction

   function automatic logic [3:0] model_decode(input logic [6:0] c);
      return {c[6], c[5], c[4], c[2]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- scoreboard for instance A ----------------
   always @(posedge clk)
      if (rst_n && a_in_valid && a_in_ready) exp_q.push_back(a_in_data);

   int         run_len, gap_len;
   logic       prev_ov;
   logic [6:0] cur_code;
   logic [3:0] exp_d;

   always @(negedge clk) begin
      if (!rst_n) begin
         run_len = 0;
         gap_len = 1000;
         prev_ov = 1'b0;
      end else begin
         if (!a_busy) chk("mon_busy_idle_pads", 32'({a_out_valid, a_io_out}), 32'({1'b0, IDLE}));
         if (a_out_valid) begin
            if (!prev_ov) begin
               chk("mon_gap_len", 32'(gap_len >= GAP_A), 32'd1);
               chk("mon_pending", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  exp_d = exp_q.pop_front();
                  chk("mon_code", 32'(a_io_out), 32'(model_encode(exp_d)));
                  chk("mon_syndrome", 32'(model_syndrome(a_io_out)), 32'd0);
                  chk("mon_decode", 32'(model_decode(a_io_out)), 32'(exp_d));
               end
               cur_code = a_io_out;
               run_len  = 1;
            end else begin
               run_len++;
               chk("mon_hold_stable", 32'(a_io_out), 32'(cur_code));
            end
            gap_len = 0;
         end else begin
            if (prev_ov) chk("mon_hold_len", 32'(run_len), 32'(HOLD_A));
            chk("mon_idle_code", 32'(a_io_out), 32'(IDLE));
            gap_len++;
         end
         prev_ov = a_out_valid;
      end
   end

   // ---------------- driver tasks (all start and end on a falling edge) ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic send_a(input logic [3:0] d);
      int t;
      a_in_data  = d;
      a_in_valid = 1'b1;
      t = 0;
      while (!a_in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("send_a_ready", 32'(a_in_ready), 32'd1);
      @(negedge clk);
      a_in_valid = 1'b0;
   endtask

   task automatic wait_ov_a();
      int t;
      t = 0;
      while (!a_out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("wait_ov_a", 32'(a_out_valid), 32'd1);
   endtask

   task automatic wait_idle_a();
      int t;
      t = 0;
      while ((a_busy || exp_q.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("wait_idle_a_busy", 32'(a_busy), 32'd0);
      chk("wait_idle_a_queue", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_idle_b();
      int t;
      t = 0;
      while (b_busy && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("wait_idle_b_busy", 32'(b_busy), 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [3:0] s[5];
      logic [3:0] x0, x1, x2;
      int acc;

      vecs[0] = '{4'b1011, 7'b1010101};
      vecs[1] = '{4'b0000, 7'b0000000};
      vecs[2] = '{4'b0001, 7'b0000111};
      vecs[3] = '{4'b1111, 7'b1111111};
      vecs[4] = '{4'b0010, 7'b0011001};
      vecs[5] = '{4'b0100, 7'b0101010};
      vecs[6] = '{4'b1000, 7'b1001011};

      a_in_data = '0; a_in_valid = 1'b0;
      b_in_data = '0; b_in_valid = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_io_out", 32'(a_io_out), 32'(IDLE));
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_sym_count", 32'(a_sym_count), 32'd0);
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      chk("rst_io_oeb", 32'(a_io_oeb), 32'd0);
      chk("rst_b_in_ready", 32'(b_in_ready), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready_a", 32'(a_in_ready), 32'd1);
      chk("post_rst_ready_b", 32'(b_in_ready), 32'd1);

      // single pulse of 1011
      a_in_data  = 4'b1011;
      a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      chk("t1_not_yet_valid", 32'(a_out_valid), 32'd0);
      chk("t1_busy_buffered", 32'(a_busy), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t1_code", 32'(a_io_out), 32'h55);
         chk("t1_valid", 32'(a_out_valid), 32'd1);
      end
      @(negedge clk);
      chk("t1_gap_code", 32'(a_io_out), 32'(IDLE));
      chk("t1_gap_valid", 32'(a_out_valid), 32'd0);
      chk("t1_gap_busy", 32'(a_busy), 32'd1);
      @(negedge clk);
      chk("t1_done_busy", 32'(a_busy), 32'd0);
      chk("t1_sym_count", 32'(a_sym_count), 32'd1);

      // table of known codewords
      for (int i = 0; i < 7; i++) begin
         send_a(vecs[i].data);
         wait_ov_a();
         chk("table_code", 32'(a_io_out), 32'(vecs[i].code));
         wait_idle_a();
      end

      // all 16 symbols in sequence
      for (int i = 0; i < 16; i++) send_a(4'(i));
      wait_idle_a();

      // back-to-back streaming on B
      do_reset();
      for (int i = 0; i < 5; i++) s[i] = 4'($urandom);
      b_in_data  = s[0];
      b_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("st_ready", 32'(b_in_ready), 32'd1);
         if (i > 0) begin
            chk("st_code", 32'(b_io_out), 32'(model_encode(s[i-1])));
            chk("st_valid", 32'(b_out_valid), 32'd1);
         end
         if (i < 4) b_in_data = s[i+1];
         else       b_in_valid = 1'b0;
      end
      @(negedge clk);
      chk("st_last_code", 32'(b_io_out), 32'(model_encode(s[4])));
      chk("st_sym_count", 32'(b_sym_count), 32'd5);
      @(negedge clk);
      chk("st_end_valid", 32'(b_out_valid), 32'd0);
      chk("st_end_code", 32'(b_io_out), 32'(IDLE));
      chk("st_end_busy", 32'(b_busy), 32'd0);

      // backpressure on A
      x0 = 4'($urandom); x1 = 4'($urandom); x2 = 4'($urandom);
      a_in_data  = x0;
      a_in_valid = 1'b1;
      @(negedge clk);
      chk("bp_ready_reload", 32'(a_in_ready), 32'd1);
      a_in_data = x1;
      @(negedge clk);
      chk("bp_first_code", 32'(a_io_out), 32'(model_encode(x0)));
      a_in_data = x2;
      for (int k = 0; k < 4; k++) begin
         chk("bp_stall", 32'(a_in_ready), 32'd0);
         @(negedge clk);
      end
      chk("bp_ready_launch", 32'(a_in_ready), 32'd1);
      @(negedge clk);
      chk("bp_second_code", 32'(a_io_out), 32'(model_encode(x1)));
      chk("bp_third_held", 32'(a_in_ready), 32'd0);
      a_in_valid = 1'b0;
      wait_idle_a();

      // random traffic on A
      for (int i = 0; i < 80; i++) begin
         a_in_valid = ($urandom_range(0, 2) == 0);
         a_in_data  = 4'($urandom);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      wait_idle_a();

      // asynchronous reset mid-hold with the buffer full
      do_reset();
      a_in_data  = 4'($urandom);
      a_in_valid = 1'b1;
      @(negedge clk);
      a_in_data = 4'($urandom);
      @(negedge clk);
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("mr_in_hold", 32'(a_out_valid), 32'd1);
      chk("mr_buf_full", 32'(a_in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_io_out", 32'(a_io_out), 32'(IDLE));
      chk("mr_out_valid", 32'(a_out_valid), 32'd0);
      chk("mr_sym_count", 32'(a_sym_count), 32'd0);
      chk("mr_busy", 32'(a_busy), 32'd0);
      exp_q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("mr_no_stale", 32'(a_out_valid), 32'd0);
      end
      chk("mr_sym_count_after", 32'(a_sym_count), 32'd0);

      // sym_count wrap on B
      do_reset();
      acc = 0;
      b_in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         b_in_data = 4'($urandom);
         if (b_in_ready) acc++;
         @(negedge clk);
      end
      b_in_valid = 1'b0;
      chk("wrap_accepts", 32'(acc), 32'd256);
      wait_idle_b();
      chk("wrap_zero", 32'(b_sym_count), 32'd0);
      b_in_data  = 4'($urandom);
      b_in_valid = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      wait_idle_b();
      chk("wrap_one", 32'(b_sym_count), 32'd1);

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_proj_encoder.md
Name: decoder_proj_encoder

Overview:
- Transmit-side counterpart of the project's 7-bit decoder input. Accepts 4-bit data symbols on a valid/ready interface and Hamming(7,4)-encodes each one.
- Drives each 7-bit codeword onto the io_out pads for a programmable number of cycles, then a programmable inter-symbol gap, so a 7-bit receiver (io_in) can sample it without a shared strobe.
- A one-entry input buffer decouples the producer from the pad-timing FSM.

Parameters:
- HOLD_CYCLES, 4: cycles each codeword is held on io_out; legal range 1..255.
- GAP_CYCLES, 1: cycles IDLE_CODE is driven between codewords; legal range 0..255.
- IDLE_CODE, 7'b0000000: value on io_out whenever no codeword is being held.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  4  data symbol {d3,d2,d1,d0}.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- io_out  output  7  codeword or IDLE_CODE, registered.
- io_oeb  output  7  pad output-enable, active-low; all 0 after reset, never changes.
- out_valid  output  1  high exactly while io_out holds a codeword.
- busy  output  1  high when the buffer is full or state != IDLE.
- sym_count  output  8  number of codewords launched, wraps 255->0.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-low.
  - Every output is registered except in_ready, which is combinational.
- Values while rst_n=0:
  - io_out=IDLE_CODE, io_oeb=7'b0000000, out_valid=0, busy=0, sym_count=0, buffer empty, state=IDLE.
  - in_ready=0 while rst_n=0, and 1 from the first cycle after deassertion.
- Encoding, with p0=d0^d1^d3, p1=d0^d2^d3, p2=d1^d2^d3:
  - io_out = {d3,d2,d1,p2,d0,p1,p0}.
- Input buffer:
  - An accept occurs on the edge where in_valid && in_ready; in_data is latched into the buffer.
  - in_ready = !buf_full || load_now.
  - This allows a same-edge drain and refill. No bubble is needed when the buffer is full and the FSM is reloading.
  - in_data is ignored when in_valid=0.
- FSM states IDLE, HOLD, GAP; counter cnt is 8 bits:
  - IDLE: if buf_full, load_now=1.
  - HOLD: cnt counts 1..HOLD_CYCLES. On the last hold cycle:
    - if GAP_CYCLES>0, go to GAP;
    - else if buf_full, load_now (back-to-back codewords);
    - else go to IDLE.
  - GAP: cnt counts 1..GAP_CYCLES. On the last gap cycle:
    - if buf_full, load_now;
    - else go to IDLE.
  - load_now: on that edge, io_out <= encode(buffer), out_valid<=1, sym_count<=sym_count+1, cnt<=1, state<=HOLD, and the buffer empties unless refilled on the same edge.
  - Leaving HOLD: io_out<=IDLE_CODE and out_valid<=0.
- Latency:
  - Symbol accepted at edge N with FSM idle: io_out carries the codeword from edge N+1 through edge N+1+HOLD_CYCLES.
  - That is exactly HOLD_CYCLES cycles of out_valid=1.
- Throughput: one codeword per HOLD_CYCLES+GAP_CYCLES cycles under continuous in_valid.
- Reset mid-operation: immediate return to reset values. The buffered symbol and the codeword in flight are discarded; no partial hold completes.
- sym_count increments once per launch and wraps modulo 256.
- busy=0 implies io_out==IDLE_CODE and out_valid=0.

Test Plan:
- Reset, then in_data=4'b1011 pulsed for one cycle with HOLD=4, GAP=1:
  - io_out=7'b1010101 with out_valid=1 for exactly 4 cycles, starting 1 edge after the accept.
  - Then IDLE_CODE for 1 cycle, then busy=0 and sym_count=1.
- Exhaustive encode: all 16 symbols sent in sequence.
  - Checkpoints: 0000->0000000, 0001->0000111, 1111->1111111.
  - The bench decodes each codeword with syndrome 0 and recovers the symbol.
- Back-to-back streaming with GAP_CYCLES=0, HOLD=1, in_valid held high for 5 symbols:
  - one codeword per cycle, in_ready stays 1, no IDLE_CODE between codewords, sym_count=5.
- Backpressure, HOLD=4 and GAP=1, three symbols offered continuously:
  - 1st is accepted and launched; 2nd is accepted into the buffer; in_ready=0 until the 2nd launches.
  - The 3rd is accepted on that same launch edge. Order is preserved.
- Reset asserted asynchronously mid-hold (cycle 2 of 4) with the buffer full:
  - io_out=IDLE_CODE and out_valid=0 immediately; sym_count=0.
  - After release, no stale codeword appears.
- Wrap: 256 symbols -> sym_count returns to 0 and the 257th launch gives sym_count=1.
